// File: rtl/ln_1to2_pkg.sv
// rtl/ln_1to2_pkg.sv - shared operator codes, sizes, state codes and range compare helper
package ln_1to2_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ADDRESS_SIZE = 8;
  localparam int DATA_SIZE    = 8;

  typedef enum logic [2:0] {
    GT_OP  = 3'd0,
    GTE_OP = 3'd1,
    LT_OP  = 3'd2,
    LTE_OP = 3'd3,
    EQ_OP  = 3'd4,
    NEQ_OP = 3'd5
  } cmp_op_t;

  typedef enum logic {
    LN_IDLE = 1'b0,
    LN_BUSY = 1'b1
  } ln_state_t;

  // Operand order is "value OP reference", e.g. GT_OP means addr > ref.
  function automatic logic cmp_op(input cmp_op_t op, input logic [31:0] ref_val,
                                  input logic [31:0] val);
    logic r;
    case (op)
      GT_OP:   r = (val >  ref_val);
      GTE_OP:  r = (val >= ref_val);
      LT_OP:   r = (val <  ref_val);
      LTE_OP:  r = (val <= ref_val);
      EQ_OP:   r = (val == ref_val);
      NEQ_OP:  r = (val != ref_val);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic range_cmp_op(input logic is_range,
                                        input cmp_op_t op1, input logic [31:0] ref1,
                                        input logic [31:0] val1,
                                        input cmp_op_t op2, input logic [31:0] ref2,
                                        input logic [31:0] val2);
    logic c1;
    logic c2;
    c1 = cmp_op(op1, ref1, val1);
    c2 = cmp_op(op2, ref2, val2);
    return is_range ? (c1 && c2) : c1;
  endfunction

endpackage

// File: rtl/ln_1to2_if.sv
// rtl/ln_1to2_if.sv - 4-phase req/ack link channel carrying one {addr,dat} word
interface ln_link_if
  import ln_1to2_pkg::*;
#(
  parameter int ASZ = ADDRESS_SIZE,
  parameter int DSZ = DATA_SIZE
);
  logic [ASZ-1:0] addr;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (output addr, output dat, output req, input ack);
  modport slave  (input addr, input dat, input req, output ack);
endinterface

// File: rtl/ln_1to2_addr_sel.sv
// rtl/ln_1to2_addr_sel.sv - combinational address-to-output select, reusable by other routers
module ln_addr_sel
  import ln_1to2_pkg::*;
#(
  parameter cmp_op_t OPER_1    = GT_OP,
  parameter int      REF_VAL_1 = 0,
  parameter logic    IS_RANGE  = FALSE,
  parameter cmp_op_t OPER_2    = GT_OP,
  parameter int      REF_VAL_2 = 0,
  parameter int      ASZ       = ADDRESS_SIZE
) (
  input  logic [ASZ-1:0] addr,
  output logic           sel
);

  logic [31:0] addr_w;

  assign addr_w = 32'(addr);

  // sel=0 when the route condition holds (output 0), else output 1.
  assign sel = !range_cmp_op(IS_RANGE, OPER_1, 32'(REF_VAL_1), addr_w,
                             OPER_2, 32'(REF_VAL_2), addr_w);

endmodule

// File: rtl/ln_1to2.sv
// rtl/ln_1to2.sv - one-input two-output address router on 4-phase req/ack links
module ln_1to2
  import ln_1to2_pkg::*;
#(
  parameter cmp_op_t OPER_1    = GT_OP,
  parameter int      REF_VAL_1 = 0,
  parameter logic    IS_RANGE  = FALSE,
  parameter cmp_op_t OPER_2    = GT_OP,
  parameter int      REF_VAL_2 = 0,
  parameter int      ASZ       = ADDRESS_SIZE,
  parameter int      DSZ       = DATA_SIZE,
  parameter int      CSZ       = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ln_link_if.slave       up,
  ln_link_if.master      dn0,
  ln_link_if.master      dn1,
  output logic [CSZ-1:0] o_0_cnt,
  output logic [CSZ-1:0] o_1_cnt,
  output logic           o_err
);

  ln_state_t      state_q, state_d;
  logic           sel_q, sel_d;
  logic           ack_q, ack_d;
  logic [1:0]     req_q, req_d;
  logic [ASZ-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DSZ-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
  logic [CSZ-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic           err_q, err_d;
  logic           in_done_q, in_done_d;
  logic           out_done_q, out_done_d;

  logic sel_now;
  logic sel_ack;
  logic oth_ack;

  ln_addr_sel #(
    .OPER_1   (OPER_1),
    .REF_VAL_1(REF_VAL_1),
    .IS_RANGE (IS_RANGE),
    .OPER_2   (OPER_2),
    .REF_VAL_2(REF_VAL_2),
    .ASZ      (ASZ)
  ) u_addr_sel (
    .addr(up.addr),
    .sel (sel_now)
  );

  assign sel_ack = sel_q ? dn1.ack : dn0.ack;
  assign oth_ack = sel_q ? dn0.ack : dn1.ack;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ack_d      = ack_q;
    req_d      = req_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    dat0_d     = dat0_q;
    dat1_d     = dat1_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    err_d      = err_q;
    in_done_d  = in_done_q;
    out_done_d = out_done_q;

    case (state_q)
      LN_IDLE: begin
        in_done_d  = 1'b0;
        out_done_d = 1'b0;
        if (dn0.ack || dn1.ack) err_d = 1'b1;
        if (up.req) begin
          sel_d   = sel_now;
          ack_d   = 1'b1;
          state_d = LN_BUSY;
          if (sel_now) begin
            addr1_d  = up.addr;
            dat1_d   = up.dat;
            req_d[1] = 1'b1;
          end else begin
            addr0_d  = up.addr;
            dat0_d   = up.dat;
            req_d[0] = 1'b1;
          end
        end
      end

      LN_BUSY: begin
        if (oth_ack) err_d = 1'b1;

        if (!up.req && ack_q) begin
          ack_d     = 1'b0;
          in_done_d = 1'b1;
        end else if (!up.req && !ack_q && !in_done_q) begin
          err_d = 1'b1;
        end

        // Delivery counts only once the sink has released ack after req dropped.
        if (sel_ack && req_q[sel_q]) begin
          req_d[sel_q] = 1'b0;
        end else if (!sel_ack && !req_q[sel_q] && !out_done_q) begin
          out_done_d = 1'b1;
          if (sel_q) cnt1_d = cnt1_q + CSZ'(1);
          else       cnt0_d = cnt0_q + CSZ'(1);
        end

        if (in_done_q && out_done_q) begin
          state_d    = LN_IDLE;
          in_done_d  = 1'b0;
          out_done_d = 1'b0;
        end
      end

      default: state_d = LN_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= LN_IDLE;
      sel_q      <= 1'b0;
      ack_q      <= 1'b0;
      req_q      <= 2'b00;
      addr0_q    <= '0;
      addr1_q    <= '0;
      dat0_q     <= '0;
      dat1_q     <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      err_q      <= 1'b0;
      in_done_q  <= 1'b0;
      out_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      req_q      <= req_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      dat0_q     <= dat0_d;
      dat1_q     <= dat1_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      err_q      <= err_d;
      in_done_q  <= in_done_d;
      out_done_q <= out_done_d;
    end
  end

  assign up.ack   = ack_q;
  assign dn0.req  = req_q[0];
  assign dn1.req  = req_q[1];
  assign dn0.addr = addr0_q;
  assign dn1.addr = addr1_q;
  assign dn0.dat  = dat0_q;
  assign dn1.dat  = dat1_q;
  assign o_0_cnt  = cnt0_q;
  assign o_1_cnt  = cnt1_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_ln_1to2.sv
// tb/tb_ln_1to2.sv - directed table-driven bench for ln_1to2 (single-compare and range instances)
module tb_ln_1to2;
  import ln_1to2_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ln_link_if #(.ASZ(8), .DSZ(8)) up_a ();
  ln_link_if #(.ASZ(8), .DSZ(8)) d0_a ();
  ln_link_if #(.ASZ(8), .DSZ(8)) d1_a ();
  ln_link_if #(.ASZ(8), .DSZ(8)) up_b ();
  ln_link_if #(.ASZ(8), .DSZ(8)) d0_b ();
  ln_link_if #(.ASZ(8), .DSZ(8)) d1_b ();

  logic [15:0] cnt_a0, cnt_a1, cnt_b0, cnt_b1;
  logic        err_a, err_b;

  ln_1to2 #(
    .OPER_1(GT_OP), .REF_VAL_1(3), .IS_RANGE(FALSE), .OPER_2(GT_OP), .REF_VAL_2(0),
    .ASZ(8), .DSZ(8), .CSZ(16)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .up(up_a), .dn0(d0_a), .dn1(d1_a),
    .o_0_cnt(cnt_a0), .o_1_cnt(cnt_a1), .o_err(err_a)
  );

  ln_1to2 #(
    .OPER_1(GTE_OP), .REF_VAL_1(2), .IS_RANGE(TRUE), .OPER_2(LT_OP), .REF_VAL_2(6),
    .ASZ(8), .DSZ(8), .CSZ(16)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .up(up_b), .dn0(d0_b), .dn1(d1_b),
    .o_0_cnt(cnt_b0), .o_1_cnt(cnt_b1), .o_err(err_b)
  );

  logic       src_req  [2];
  logic [7:0] src_addr [2];
  logic [7:0] src_dat  [2];
  logic       en [2][2];
  logic       gl [2][2];

  logic        ack_o  [2];
  logic        req_o  [2][2];
  logic [7:0]  addr_o [2][2];
  logic [7:0]  dat_o  [2][2];
  logic [15:0] cnt_o  [2][2];
  logic        err_o  [2];

  assign up_a.req = src_req[0];  assign up_a.addr = src_addr[0];  assign up_a.dat = src_dat[0];
  assign up_b.req = src_req[1];  assign up_b.addr = src_addr[1];  assign up_b.dat = src_dat[1];

  // Sinks acknowledge with zero delay when enabled; gl injects stray ack pulses.
  assign d0_a.ack = (d0_a.req & en[0][0]) | gl[0][0];
  assign d1_a.ack = (d1_a.req & en[0][1]) | gl[0][1];
  assign d0_b.ack = (d0_b.req & en[1][0]) | gl[1][0];
  assign d1_b.ack = (d1_b.req & en[1][1]) | gl[1][1];

  assign ack_o[0] = up_a.ack;       assign ack_o[1] = up_b.ack;
  assign req_o[0][0] = d0_a.req;    assign req_o[0][1] = d1_a.req;
  assign req_o[1][0] = d0_b.req;    assign req_o[1][1] = d1_b.req;
  assign addr_o[0][0] = d0_a.addr;  assign addr_o[0][1] = d1_a.addr;
  assign addr_o[1][0] = d0_b.addr;  assign addr_o[1][1] = d1_b.addr;
  assign dat_o[0][0] = d0_a.dat;    assign dat_o[0][1] = d1_a.dat;
  assign dat_o[1][0] = d0_b.dat;    assign dat_o[1][1] = d1_b.dat;
  assign cnt_o[0][0] = cnt_a0;      assign cnt_o[0][1] = cnt_a1;
  assign cnt_o[1][0] = cnt_b0;      assign cnt_o[1][1] = cnt_b1;
  assign err_o[0] = err_a;          assign err_o[1] = err_b;

  typedef struct {
    int         inst;
    logic [7:0] addr;
    logic [7:0] dat;
    int         sel;
    int         c0;
    int         c1;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] last_addr [2][2];
  logic [7:0] last_dat  [2][2];
  int total;
  int bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic raise(input int i, input logic [7:0] a, input logic [7:0] d);
    src_addr[i] = a;
    src_dat[i]  = d;
    src_req[i]  = 1'b1;
  endtask

  task automatic wait_ack(input int i, input logic v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_o[i] !== v && n < 50);
  endtask

  task automatic wait_cnt(input int i, input int k, input int exp, input string nm);
    for (int n = 0; n < 50 && cnt_o[i][k] != 16'(exp); n++) @(negedge clk);
    chk(nm, cnt_o[i][k], exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int i;
    int s;
    int n;
    i = v.inst;
    s = v.sel;
    @(negedge clk);
    raise(i, v.addr, v.dat);
    wait_ack(i, 1'b1, n);
    chk($sformatf("v%0d_latency", idx), n, 1);
    chk($sformatf("v%0d_req_sel", idx), req_o[i][s], 1);
    chk($sformatf("v%0d_req_oth", idx), req_o[i][1-s], 0);
    chk($sformatf("v%0d_addr", idx), addr_o[i][s], v.addr);
    chk($sformatf("v%0d_dat", idx), dat_o[i][s], v.dat);
    chk($sformatf("v%0d_addr_oth", idx), addr_o[i][1-s], last_addr[i][1-s]);
    chk($sformatf("v%0d_dat_oth", idx), dat_o[i][1-s], last_dat[i][1-s]);
    last_addr[i][s] = v.addr;
    last_dat[i][s]  = v.dat;
    src_req[i] = 1'b0;
    wait_ack(i, 1'b0, n);
    chk($sformatf("v%0d_ack_low", idx), ack_o[i], 0);
    wait_cnt(i, s, (s == 0) ? v.c0 : v.c1, $sformatf("v%0d_cnt_sel", idx));
    chk($sformatf("v%0d_cnt0", idx), cnt_o[i][0], v.c0);
    chk($sformatf("v%0d_cnt1", idx), cnt_o[i][1], v.c1);
    chk($sformatf("v%0d_err", idx), err_o[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_req[i] = 1'b0;  src_addr[i] = 8'h00;  src_dat[i] = 8'h00;
      for (int k = 0; k < 2; k++) begin
        en[i][k] = 1'b1;  gl[i][k] = 1'b0;
        last_addr[i][k] = 8'h00;  last_dat[i][k] = 8'h00;
      end
    end

    // inst, addr, dat, expected output, expected cnt0, cnt1
    vecs[0] = '{0, 8'd5, 8'h11, 0, 1, 0};
    vecs[1] = '{0, 8'd2, 8'h22, 1, 1, 1};
    vecs[2] = '{1, 8'd0, 8'h30, 1, 0, 1};
    vecs[3] = '{1, 8'd1, 8'h31, 1, 0, 2};
    vecs[4] = '{1, 8'd2, 8'h32, 0, 1, 2};
    vecs[5] = '{1, 8'd3, 8'h33, 0, 2, 2};
    vecs[6] = '{1, 8'd4, 8'h34, 0, 3, 2};
    vecs[7] = '{1, 8'd5, 8'h35, 0, 4, 2};
    vecs[8] = '{1, 8'd6, 8'h36, 1, 4, 3};
    vecs[9] = '{1, 8'd7, 8'h37, 1, 4, 4};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_ack", i), ack_o[i], 0);
      chk($sformatf("rst%0d_req0", i), req_o[i][0], 0);
      chk($sformatf("rst%0d_req1", i), req_o[i][1], 0);
      chk($sformatf("rst%0d_cnt0", i), cnt_o[i][0], 0);
      chk($sformatf("rst%0d_cnt1", i), cnt_o[i][1], 0);
      chk($sformatf("rst%0d_err", i), err_o[i], 0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) run_vec(vecs[v], v);

    // Slow sink on output 0 while the source finishes immediately.
    @(negedge clk);
    en[0][0] = 1'b0;
    raise(0, 8'd5, 8'h55);
    wait_ack(0, 1'b1, n);
    chk("hold_accept", ack_o[0], 1);
    src_req[0] = 1'b0;
    wait_ack(0, 1'b0, n);
    chk("hold_ack_fall", n, 1);
    chk("hold_req0_up", req_o[0][0], 1);
    raise(0, 8'd6, 8'h66);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_no_accept", k), ack_o[0], 0);
      chk($sformatf("hold%0d_req0", k), req_o[0][0], 1);
      chk($sformatf("hold%0d_cnt0", k), cnt_o[0][0], 1);
    end
    en[0][0] = 1'b1;
    @(negedge clk);
    chk("hold_req0_drop", req_o[0][0], 0);
    chk("hold_cnt_wait", cnt_o[0][0], 1);
    @(negedge clk);
    chk("hold_cnt_inc", cnt_o[0][0], 2);
    wait_ack(0, 1'b1, n);
    chk("hold_next_accept", ack_o[0], 1);
    chk("hold_next_addr", addr_o[0][0], 6);
    chk("hold_next_dat", dat_o[0][0], 8'h66);
    src_req[0] = 1'b0;
    wait_ack(0, 1'b0, n);
    wait_cnt(0, 0, 3, "hold_next_cnt");
    chk("hold_err", err_o[0], 0);

    // Stray ack on the idle output during an output-0 transfer.
    @(negedge clk);
    en[0][0] = 1'b0;
    raise(0, 8'd4, 8'h44);
    wait_ack(0, 1'b1, n);
    chk("err_accept", ack_o[0], 1);
    src_req[0] = 1'b0;
    chk("err_before", err_o[0], 0);
    gl[0][1] = 1'b1;
    @(negedge clk);
    gl[0][1] = 1'b0;
    chk("err_set", err_o[0], 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err_o[0], 1);
    chk("err_req0", req_o[0][0], 1);
    en[0][0] = 1'b1;
    wait_cnt(0, 0, 4, "err_cnt0");
    chk("err_cnt1", cnt_o[0][1], 1);
    chk("err_still", err_o[0], 1);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    en[0][0] = 1'b0;
    raise(0, 8'd7, 8'h77);
    wait_ack(0, 1'b1, n);
    src_req[0] = 1'b0;
    wait_ack(0, 1'b0, n);
    chk("ar_req0_up", req_o[0][0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ack", ack_o[0], 0);
    chk("ar_req0", req_o[0][0], 0);
    chk("ar_req1", req_o[0][1], 0);
    chk("ar_cnt0", cnt_o[0][0], 0);
    chk("ar_cnt1", cnt_o[0][1], 0);
    chk("ar_err", err_o[0], 0);
    chk("ar_addr0", addr_o[0][0], 0);
    chk("ar_dat0", dat_o[0][0], 0);
    en[0][0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    raise(0, 8'd1, 8'h5a);
    wait_ack(0, 1'b1, n);
    chk("ar2_latency", n, 1);
    chk("ar2_req1", req_o[0][1], 1);
    chk("ar2_req0", req_o[0][0], 0);
    chk("ar2_addr1", addr_o[0][1], 1);
    chk("ar2_dat1", dat_o[0][1], 8'h5a);
    src_req[0] = 1'b0;
    wait_ack(0, 1'b0, n);
    wait_cnt(0, 1, 1, "ar2_cnt1");
    chk("ar2_cnt0", cnt_o[0][0], 0);
    chk("ar2_err", err_o[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
